// File: rtl/read_req_id_mc_fifo_pkg.sv
// rtl/read_req_id_mc_fifo_pkg.sv - shared frontend command types for the read request ID FIFO
package read_req_id_mc_fifo_pkg;

    localparam int REQ_ID_W = 5;

    // One read request ID as carried through the frontend
    typedef logic [REQ_ID_W-1:0] req_id_t;

    // Channel index wide enough to hold every legal channel count (1..16)
    typedef logic [4:0] ch_idx_t;

    // Channel select width; a single channel still gets a 1-bit select
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/req_id_fifo_ch.sv
// rtl/req_id_fifo_ch.sv - one circular request ID channel with registered flags
module req_id_fifo_ch #(
    parameter int DATA_WIDTH   = 5,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12,
    localparam int PW          = ADDR_WIDTH + 1,
    localparam int DEPTH       = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full,
    output logic                  afull,
    output logic [PW-1:0]         count
);

    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_nxt;
    logic [PW-1:0]         rd_nxt;
    logic [PW-1:0]         cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Next-state pointers; flags are derived from these so they are valid the cycle after an op
    always_comb begin
        wr_nxt  = wr_ptr + PW'(push);
        rd_nxt  = rd_ptr + PW'(pop);
        cnt_nxt = wr_nxt - rd_nxt;
    end

    // Pointer and flag registers; reset discards all entries at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            afull  <= 1'b0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            empty  <= (wr_nxt == rd_nxt);
            full   <= (wr_nxt == {~rd_nxt[PW-1], rd_nxt[PW-2:0]});
            afull  <= (cnt_nxt >= AFULL_LVL);
            count  <= cnt_nxt;
        end
    end

    // Entry storage; a write to a full channel with a same-cycle pop reuses the head slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= data;
        end
    end

    // Fall-through head of the channel
    assign head = mem[rd_ptr[ADDR_WIDTH-1:0]];

    a_reset_vals: assert property (@(posedge clk)
        !rst_n |-> (wr_ptr == '0 && rd_ptr == '0 && empty && !full && count == '0));

    a_wr_step: assert property (@(posedge clk) disable iff (!rst_n)
        $past(rst_n) |-> (wr_ptr == $past(wr_ptr) + PW'($past(push))));

    a_rd_step: assert property (@(posedge clk) disable iff (!rst_n)
        $past(rst_n) |-> (rd_ptr == $past(rd_ptr) + PW'($past(pop))));

    a_wr_data: assert property (@(posedge clk) disable iff (!rst_n)
        push |=> (mem[$past(wr_ptr[ADDR_WIDTH-1:0])] == $past(data)));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        pop |-> !empty);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        (push && !pop) |-> !full);

endmodule

// File: rtl/read_req_id_mc_fifo.sv
// rtl/read_req_id_mc_fifo.sv - multi-channel read request ID FIFO with sticky error flags
module read_req_id_mc_fifo
    import read_req_id_mc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 5,
    parameter int ADDR_WIDTH   = 4,
    parameter int NUM_CH       = 4,
    parameter int AFULL_THRESH = 12,
    localparam int CH_W        = ch_width(NUM_CH),
    localparam int CW          = ADDR_WIDTH + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic [CH_W-1:0]      i_wr_ch,
    input  req_id_t              i_data,
    input  logic                 i_rd_en,
    input  logic [CH_W-1:0]      i_rd_ch,
    input  logic                 i_err_clr,
    output req_id_t              o_data,
    output logic [NUM_CH-1:0]    o_empty,
    output logic [NUM_CH-1:0]    o_full,
    output logic [NUM_CH-1:0]    o_afull,
    output logic [NUM_CH*CW-1:0] o_count,
    output logic                 o_ovf_err,
    output logic                 o_udf_err
);

    localparam ch_idx_t NUM_CH_IDX = ch_idx_t'(NUM_CH);

    ch_idx_t               wr_idx;
    ch_idx_t               rd_idx;
    logic                  wr_ch_ok;
    logic                  rd_ch_ok;
    logic                  sel_empty;
    logic                  sel_full;
    logic                  rd_acc;
    logic                  pass_thru;
    logic                  wr_acc;
    logic                  wr_rej;
    logic                  rd_rej;
    logic [NUM_CH-1:0]     push;
    logic [NUM_CH-1:0]     pop;
    logic [DATA_WIDTH-1:0] head [NUM_CH];

    // Channel decode and acceptance: reads never pass on an empty channel, writes to a full one only with a same-channel pop
    always_comb begin
        wr_idx    = ch_idx_t'(i_wr_ch);
        rd_idx    = ch_idx_t'(i_rd_ch);
        wr_ch_ok  = (wr_idx < NUM_CH_IDX);
        rd_ch_ok  = (rd_idx < NUM_CH_IDX);
        sel_empty = rd_ch_ok ? o_empty[i_rd_ch] : 1'b1;
        sel_full  = wr_ch_ok ? o_full[i_wr_ch] : 1'b1;
        rd_acc    = i_rd_en && rd_ch_ok && !sel_empty;
        pass_thru = rd_acc && (i_rd_ch == i_wr_ch);
        wr_acc    = i_wr_en && wr_ch_ok && (!sel_full || pass_thru);
        wr_rej    = i_wr_en && !wr_acc;
        rd_rej    = i_rd_en && !rd_acc;
        push      = '0;
        pop       = '0;
        if (wr_acc) begin
            push[i_wr_ch] = 1'b1;
        end
        if (rd_acc) begin
            pop[i_rd_ch] = 1'b1;
        end
        o_data = rd_ch_ok ? req_id_t'(head[i_rd_ch]) : '0;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        req_id_fifo_ch #(
            .DATA_WIDTH   (DATA_WIDTH),
            .ADDR_WIDTH   (ADDR_WIDTH),
            .AFULL_THRESH (AFULL_THRESH)
        ) u_ch (
            .clk   (i_clk),
            .rst_n (i_rst_n),
            .push  (push[c]),
            .pop   (pop[c]),
            .data  (i_data),
            .head  (head[c]),
            .empty (o_empty[c]),
            .full  (o_full[c]),
            .afull (o_afull[c]),
            .count (o_count[c*CW +: CW])
        );
    end

    // Sticky error flags; a new rejection wins over a same-cycle clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf_err <= 1'b0;
            o_udf_err <= 1'b0;
        end else begin
            if (wr_rej) begin
                o_ovf_err <= 1'b1;
            end else if (i_err_clr) begin
                o_ovf_err <= 1'b0;
            end
            if (rd_rej) begin
                o_udf_err <= 1'b1;
            end else if (i_err_clr) begin
                o_udf_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_read_req_id_mc_fifo.sv
// tb/tb_read_req_id_mc_fifo.sv - self-checking bench for the multi-channel request ID FIFO
module tb_read_req_id_mc_fifo;
    import read_req_id_mc_fifo_pkg::*;

    localparam int NCH   = 4;
    localparam int CW    = 5;
    localparam int DEPTH = 16;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        wr_en   = 1'b0;
    logic        rd_en   = 1'b0;
    logic        err_clr = 1'b0;
    logic [1:0]  wr_ch   = '0;
    logic [1:0]  rd_ch   = '0;
    req_id_t     wdata   = '0;
    req_id_t     rdata;
    logic [3:0]  empty;
    logic [3:0]  full;
    logic [3:0]  afull;
    logic [19:0] count;
    logic        ovf;
    logic        udf;

    int      checks   = 0;
    int      failures = 0;
    req_id_t q [NCH][$];
    logic    m_ovf = 1'b0;
    logic    m_udf = 1'b0;
    req_id_t pre_data;

    typedef struct {
        logic    we;
        int      wc;
        req_id_t wd;
        logic    re;
        int      rc;
        logic    clr;
        logic    chk_data;
        req_id_t exp_data;
        int      chk_ch;
        int      exp_cnt;
        logic    exp_ovf;
        logic    exp_udf;
    } vec_t;

    vec_t vecs [10];

    read_req_id_mc_fifo #(
        .DATA_WIDTH   (5),
        .ADDR_WIDTH   (4),
        .NUM_CH       (4),
        .AFULL_THRESH (12)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_ch   (wr_ch),
        .i_data    (wdata),
        .i_rd_en   (rd_en),
        .i_rd_ch   (rd_ch),
        .i_err_clr (err_clr),
        .o_data    (rdata),
        .o_empty   (empty),
        .o_full    (full),
        .o_afull   (afull),
        .o_count   (count),
        .o_ovf_err (ovf),
        .o_udf_err (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("count_ch%0d", c), 32'(count[c*CW +: CW]), 32'(q[c].size()));
            chk($sformatf("empty_ch%0d", c), 32'(empty[c]), 32'(q[c].size() == 0));
            chk($sformatf("full_ch%0d", c), 32'(full[c]), 32'(q[c].size() == DEPTH));
            chk($sformatf("afull_ch%0d", c), 32'(afull[c]), 32'(q[c].size() >= 12));
        end
        chk("ovf_err", 32'(ovf), 32'(m_ovf));
        chk("udf_err", 32'(udf), 32'(m_udf));
    endtask

    // One clock of stimulus; the queue model predicts acceptance and the popped head
    task automatic step(input logic we, input int wc, input req_id_t wd,
                        input logic re, input int rc, input logic clr);
        logic rd_ok;
        logic wr_ok;
        @(negedge clk);
        wr_en   = we;
        wr_ch   = 2'(wc);
        wdata   = wd;
        rd_en   = re;
        rd_ch   = 2'(rc);
        err_clr = clr;
        #1;
        pre_data = rdata;
        rd_ok = re && (q[rc].size() != 0);
        wr_ok = we && ((q[wc].size() < DEPTH) || (rd_ok && rc == wc));
        if (rd_ok) begin
            chk($sformatf("head_ch%0d", rc), 32'(rdata), 32'(q[rc][0]));
        end
        @(posedge clk);
        if (rd_ok) begin
            void'(q[rc].pop_front());
        end
        if (wr_ok) begin
            q[wc].push_back(wd);
        end
        m_ovf = (we && !wr_ok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_udf = (re && !rd_ok) ? 1'b1 : (clr ? 1'b0 : m_udf);
        #1;
        check_state();
    endtask

    task automatic drain(input int ch);
        while (q[ch].size() != 0) begin
            step(1'b0, 0, 5'h00, 1'b1, ch, 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 0, 5'h07, 1'b1, 0, 1'b0, 1'b0, 5'h00, 0, 1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 0, 5'h00, 1'b1, 0, 1'b0, 1'b1, 5'h07, 0, 0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 0, 5'h00, 1'b0, 0, 1'b1, 1'b0, 5'h00, 0, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1, 5'h11, 1'b0, 0, 1'b0, 1'b0, 5'h00, 1, 1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 2, 5'h12, 1'b1, 1, 1'b0, 1'b1, 5'h11, 1, 0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 0, 5'h00, 1'b0, 2, 1'b0, 1'b0, 5'h00, 2, 1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 0, 5'h00, 1'b1, 2, 1'b0, 1'b1, 5'h12, 2, 0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 0, 5'h00, 1'b1, 3, 1'b0, 1'b0, 5'h00, 3, 0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 0, 5'h00, 1'b1, 3, 1'b1, 1'b0, 5'h00, 3, 0, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 0, 5'h00, 1'b0, 0, 1'b1, 1'b0, 5'h00, 3, 0, 1'b0, 1'b0};

        #1 rst_n = 1'b0;
        #12;
        chk("rst_empty", 32'(empty), 32'hF);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_afull", 32'(afull), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_udf", 32'(udf), 32'h0);
        chk("rst_data", 32'(rdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].we, vecs[i].wc, vecs[i].wd, vecs[i].re, vecs[i].rc, vecs[i].clr);
            chk($sformatf("vec%0d_cnt", i), 32'(count[vecs[i].chk_ch*CW +: CW]), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_udf", i), 32'(udf), 32'(vecs[i].exp_udf));
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d_data", i), 32'(pre_data), 32'(vecs[i].exp_data));
            end
        end

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 2, 5'(i), 1'b0, 0, 1'b0);
        end
        chk("fill2_full", 32'(full[2]), 32'h1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 0, 5'h00, 1'b1, 2, 1'b0);
            chk("fill2_order", 32'(pre_data), 32'(i));
        end
        chk("fill2_empty", 32'(empty[2]), 32'h1);

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1, 5'(i + 16), 1'b0, 0, 1'b0);
        end
        step(1'b1, 1, 5'h1F, 1'b1, 1, 1'b0);
        chk("pass_head", 32'(pre_data), 32'h10);
        chk("pass_cnt", 32'(count[1*CW +: CW]), 32'd16);
        chk("pass_ovf", 32'(ovf), 32'h0);
        step(1'b1, 1, 5'h15, 1'b0, 1, 1'b0);
        chk("drop_ovf", 32'(ovf), 32'h1);
        chk("drop_cnt", 32'(count[1*CW +: CW]), 32'd16);
        step(1'b0, 0, 5'h00, 1'b0, 0, 1'b1);
        drain(1);

        for (int i = 0; i < 11; i++) begin
            step(1'b1, 3, 5'(i + 3), 1'b0, 0, 1'b0);
        end
        chk("afull_11", 32'(afull[3]), 32'h0);
        step(1'b1, 3, 5'h0E, 1'b0, 0, 1'b0);
        chk("afull_12", 32'(afull[3]), 32'h1);
        step(1'b0, 0, 5'h00, 1'b1, 3, 1'b0);
        chk("afull_pop", 32'(afull[3]), 32'h0);
        drain(3);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 0, 5'(i + 20), 1'b0, 0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 0, 5'($urandom_range(0, 31)), 1'b1, 0, 1'b0);
            chk("wrap_cnt_le16", 32'(count[0 +: CW] <= 5'd16), 32'h1);
        end
        drain(0);

        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1, 5'(i + 1), 1'b0, 0, 1'b0);
        end
        @(negedge clk);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_empty", 32'(empty), 32'hF);
        chk("midrst_count", 32'(count), 32'h0);
        for (int c = 0; c < NCH; c++) begin
            q[c].delete();
        end
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1, 5'h0A, 1'b0, 1, 1'b0);
        chk("postrst_data", 32'(rdata), 32'h0A);
        chk("postrst_cnt", 32'(count[1*CW +: CW]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
